battle_ctrl: RTL and testbench
==============================

BATTLE_CTRL -- requirements
Module: battle_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  HP_MAX  100  player and enemy HP ceiling and reload value
  ATK_DMG  20  enemy HP lost per player attack
  HEAL_AMT  15  player HP gained per heal
  ENEMY_DMG  10  player HP lost per enemy turn
  STEP  4  sprite x pixels moved per animation frame
  ANIM_FRAMES  16  frame ticks per attack animation (even)
  ENEMY_DELAY  32  frame ticks spent in enemy turn
  FLASH_FRAMES  8  frame ticks hit_flash stays high
  X_HOME  200  sprite rest x; Y_HOME  400  sprite rest y
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  system clock
  rst  in  1  reset, asynchronous, active-high
  frame_tick  in  1  one-clk pulse per video frame (vs rising edge, pre-synchronised to clk)
  switch  in  7  raw board switches; [0] attack, [1] heal, [6] restart, others unused
  sprite_x  out  10  battle sprite x origin for the screen renderer
  sprite_y  out  10  battle sprite y origin
  player_hp  out  8  current player HP
  enemy_hp  out  8  current enemy HP
  state  out  3  current FSM state code
  hit_flash  out  1  high while the last damage flash is active
  busy  out  1  high in every state except PLAYER_TURN, VICTORY, DEFEAT

Function
REQ-003 switch[0], [1] and [6] SHALL each pass through a 2-flop synchroniser and a rising-edge detector; the FSM acts on the third clk rising edge after the switch change is first sampled.
REQ-004 States SHALL be PLAYER_TURN=0, ANIM=1, RESOLVE=2, ENEMY_TURN=3, VICTORY=4, DEFEAT=5; codes 6 and 7 SHALL go to PLAYER_TURN on the next clk.
REQ-005 In PLAYER_TURN, an attack edge SHALL go to ANIM with the frame counter cleared.
REQ-006 In PLAYER_TURN, a heal edge SHALL set player_hp = min(player_hp + HEAL_AMT, HP_MAX) and go to ENEMY_TURN; the sum SHALL be computed 9 bits wide so it cannot overflow.
REQ-007 If attack and heal edges occur in the same cycle, attack SHALL win and the heal edge SHALL be dropped.
REQ-008 Action edges arriving in any state other than PLAYER_TURN SHALL be discarded, not queued.
REQ-009 In ANIM, each frame_tick SHALL increment the frame counter.
  - Ticks 1..ANIM_FRAMES/2: sprite_x += STEP.
  - Remaining ticks: sprite_x -= STEP.
  - On tick ANIM_FRAMES: sprite_x = X_HOME exactly, go to RESOLVE.
REQ-010 RESOLVE SHALL last one clk.
  - enemy_hp = enemy_hp - ATK_DMG, saturating at 0.
  - hit_flash counter loads FLASH_FRAMES.
  - Next state: VICTORY if the new enemy_hp is 0, else ENEMY_TURN.
REQ-011 ENEMY_TURN SHALL count ENEMY_DELAY frame_ticks; on the last one:
  - player_hp = player_hp - ENEMY_DMG, saturating at 0.
  - hit_flash counter loads FLASH_FRAMES.
  - Next state: DEFEAT if the new player_hp is 0, else PLAYER_TURN.
REQ-012 In VICTORY or DEFEAT, a restart edge SHALL reload both HPs to HP_MAX, set sprite to home, clear counters and go to PLAYER_TURN; a restart edge in any other state SHALL be ignored.
REQ-013 hit_flash SHALL be high while the flash counter is nonzero; the counter SHALL decrement once per frame_tick; a reload while active SHALL restart it at FLASH_FRAMES.
REQ-014 sprite_y SHALL stay Y_HOME at all times.
REQ-015 All outputs SHALL be registered; frame_tick SHALL have no effect outside ANIM, ENEMY_TURN and the flash counter.

Reset
REQ-016 While rst is high, the block SHALL immediately hold:
  - state = PLAYER_TURN.
  - player_hp = enemy_hp = HP_MAX.
  - sprite_x = X_HOME, sprite_y = Y_HOME.
  - hit_flash = 0, busy = 0.
  - All counters and synchroniser/edge flops = 0.
REQ-017 Reset asserted mid-ANIM or mid-ENEMY_TURN SHALL abandon the turn with no HP change.

Structure
REQ-018 State codes and parameter defaults SHALL live in shared package battle_pkg for reuse by battle_screen.
REQ-019 Synchroniser plus edge detect SHALL be one sub-module, switch_edge, instantiated once per used switch bit.

Verification
REQ-020 Reset, then attack edge, then 16 frame_ticks -> sprite_x peaks at 232 after tick 8 and is 200 after tick 16; enemy_hp 80; hit_flash high; state 3.
REQ-021 From ENEMY_TURN, 32 frame_ticks -> player_hp 90; state 0.
REQ-022 With player_hp 90, heal edge -> player_hp 100 (saturated); state 3.
REQ-023 Five full attack/enemy rounds -> enemy_hp 0 after the fifth RESOLVE; state 4; then restart edge -> both HP 100; state 0.
REQ-024 Attack and heal rising together -> ANIM entered and player_hp unchanged; an attack edge during ANIM is ignored (enemy_hp drops by exactly 20).
REQ-025 rst pulsed at ANIM tick 5 -> sprite_x 200, enemy_hp 100, state 0 while rst is still high.

Source files
------------

// File: rtl/battle_pkg.sv
// Shared state codes, parameter defaults and saturating HP helpers for the battle
// controller and the battle screen renderer.
package battle_pkg;

    typedef enum logic [2:0] {
        PLAYER_TURN = 3'd0,
        ANIM        = 3'd1,
        RESOLVE     = 3'd2,
        ENEMY_TURN  = 3'd3,
        VICTORY     = 3'd4,
        DEFEAT      = 3'd5
    } state_t;

    localparam int HP_MAX_D       = 100;
    localparam int ATK_DMG_D      = 20;
    localparam int HEAL_AMT_D     = 15;
    localparam int ENEMY_DMG_D    = 10;
    localparam int STEP_D         = 4;
    localparam int ANIM_FRAMES_D  = 16;
    localparam int ENEMY_DELAY_D  = 32;
    localparam int FLASH_FRAMES_D = 8;
    localparam int X_HOME_D       = 200;
    localparam int Y_HOME_D       = 400;

    function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : 8'd0;
    endfunction

    // Sum is formed one bit wider so a full-scale HP plus heal cannot wrap.
    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] ceil);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, ceil}) ? ceil : sum[7:0];
    endfunction

endpackage

// File: rtl/switch_edge.sv
// Two-flop synchroniser for one raw board switch followed by a rising-edge detector.
module switch_edge (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic rise
);

    logic sync1_r;
    logic sync2_r;
    logic prev_r;

    // Synchroniser chain plus the delayed copy used for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    assign rise = sync2_r & ~prev_r;

endmodule

// File: rtl/battle_ctrl.sv
// Turn-based battle controller: player actions, attack animation, damage resolution,
// enemy turn, victory/defeat and restart, with a frame-timed hit flash.
module battle_ctrl
    import battle_pkg::*;
#(
    parameter int HP_MAX       = HP_MAX_D,
    parameter int ATK_DMG      = ATK_DMG_D,
    parameter int HEAL_AMT     = HEAL_AMT_D,
    parameter int ENEMY_DMG    = ENEMY_DMG_D,
    parameter int STEP         = STEP_D,
    parameter int ANIM_FRAMES  = ANIM_FRAMES_D,
    parameter int ENEMY_DELAY  = ENEMY_DELAY_D,
    parameter int FLASH_FRAMES = FLASH_FRAMES_D,
    parameter int X_HOME       = X_HOME_D,
    parameter int Y_HOME       = Y_HOME_D
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic [6:0] switch,
    output logic [9:0] sprite_x,
    output logic [9:0] sprite_y,
    output logic [7:0] player_hp,
    output logic [7:0] enemy_hp,
    output logic [2:0] state,
    output logic       hit_flash,
    output logic       busy
);

    localparam logic [7:0] HP_MAX_V     = 8'(HP_MAX);
    localparam logic [7:0] ATK_V        = 8'(ATK_DMG);
    localparam logic [7:0] HEAL_V       = 8'(HEAL_AMT);
    localparam logic [7:0] EDMG_V       = 8'(ENEMY_DMG);
    localparam logic [9:0] STEP_V       = 10'(STEP);
    localparam logic [7:0] ANIM_HALF_V  = 8'(ANIM_FRAMES / 2);
    localparam logic [7:0] ANIM_LAST_V  = 8'(ANIM_FRAMES);
    localparam logic [7:0] ENEMY_LAST_V = 8'(ENEMY_DELAY - 1);
    localparam logic [7:0] FLASH_V      = 8'(FLASH_FRAMES);
    localparam logic [9:0] X_HOME_V     = 10'(X_HOME);
    localparam logic [9:0] Y_HOME_V     = 10'(Y_HOME);

    state_t     st_r;
    logic [7:0] frame_cnt_r;
    logic [7:0] flash_cnt_r;
    logic [7:0] flash_next_s;
    logic [7:0] frame_inc_s;
    logic [7:0] enemy_hit_s;
    logic [7:0] player_hit_s;
    logic [7:0] player_heal_s;
    logic       atk_s;
    logic       heal_s;
    logic       restart_s;
    logic       enemy_last_s;
    logic       flash_load_s;
    logic       flash_clr_s;
    logic       unused_s;

    switch_edge u_atk     (.clk(clk), .rst(rst), .raw(switch[0]), .rise(atk_s));
    switch_edge u_heal    (.clk(clk), .rst(rst), .raw(switch[1]), .rise(heal_s));
    switch_edge u_restart (.clk(clk), .rst(rst), .raw(switch[6]), .rise(restart_s));

    assign unused_s      = ^switch[5:2];
    assign frame_inc_s   = frame_cnt_r + 8'd1;
    assign enemy_hit_s   = sat_sub(enemy_hp, ATK_V);
    assign player_hit_s  = sat_sub(player_hp, EDMG_V);
    assign player_heal_s = sat_add(player_hp, HEAL_V, HP_MAX_V);
    assign enemy_last_s  = (st_r == ENEMY_TURN) && frame_tick && (frame_cnt_r == ENEMY_LAST_V);
    assign flash_load_s  = (st_r == RESOLVE) || enemy_last_s;
    assign flash_clr_s   = restart_s && ((st_r == VICTORY) || (st_r == DEFEAT));
    assign state         = st_r;

    // Flash counter next value: restart clears, a fresh hit reloads, frames drain it.
    always_comb begin
        flash_next_s = flash_cnt_r;
        if (flash_clr_s) begin
            flash_next_s = 8'd0;
        end else if (flash_load_s) begin
            flash_next_s = FLASH_V;
        end else if (frame_tick && (flash_cnt_r != 8'd0)) begin
            flash_next_s = flash_cnt_r - 8'd1;
        end else begin
            flash_next_s = flash_cnt_r;
        end
    end

    // Flash counter and its registered output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flash_cnt_r <= 8'd0;
            hit_flash   <= 1'b0;
        end else begin
            flash_cnt_r <= flash_next_s;
            hit_flash   <= (flash_next_s != 8'd0);
        end
    end

    // Battle FSM with registered HP, sprite position and busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_r        <= PLAYER_TURN;
            player_hp   <= HP_MAX_V;
            enemy_hp    <= HP_MAX_V;
            sprite_x    <= X_HOME_V;
            sprite_y    <= Y_HOME_V;
            frame_cnt_r <= 8'd0;
            busy        <= 1'b0;
        end else begin
            sprite_y <= Y_HOME_V;
            case (st_r)
                PLAYER_TURN: begin
                    if (atk_s) begin
                        st_r        <= ANIM;
                        frame_cnt_r <= 8'd0;
                        busy        <= 1'b1;
                    end else if (heal_s) begin
                        player_hp   <= player_heal_s;
                        st_r        <= ENEMY_TURN;
                        frame_cnt_r <= 8'd0;
                        busy        <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ANIM: begin
                    busy <= 1'b1;
                    if (frame_tick) begin
                        frame_cnt_r <= frame_inc_s;
                        if (frame_inc_s == ANIM_LAST_V) begin
                            sprite_x <= X_HOME_V;
                            st_r     <= RESOLVE;
                        end else if (frame_inc_s <= ANIM_HALF_V) begin
                            sprite_x <= sprite_x + STEP_V;
                        end else begin
                            sprite_x <= sprite_x - STEP_V;
                        end
                    end
                end
                RESOLVE: begin
                    enemy_hp    <= enemy_hit_s;
                    frame_cnt_r <= 8'd0;
                    if (enemy_hit_s == 8'd0) begin
                        st_r <= VICTORY;
                        busy <= 1'b0;
                    end else begin
                        st_r <= ENEMY_TURN;
                        busy <= 1'b1;
                    end
                end
                ENEMY_TURN: begin
                    if (enemy_last_s) begin
                        player_hp   <= player_hit_s;
                        frame_cnt_r <= 8'd0;
                        busy        <= 1'b0;
                        st_r        <= (player_hit_s == 8'd0) ? DEFEAT : PLAYER_TURN;
                    end else if (frame_tick) begin
                        frame_cnt_r <= frame_inc_s;
                    end else begin
                        busy <= 1'b1;
                    end
                end
                VICTORY, DEFEAT: begin
                    busy <= 1'b0;
                    if (restart_s) begin
                        player_hp   <= HP_MAX_V;
                        enemy_hp    <= HP_MAX_V;
                        sprite_x    <= X_HOME_V;
                        frame_cnt_r <= 8'd0;
                        st_r        <= PLAYER_TURN;
                    end
                end
                default: begin
                    st_r        <= PLAYER_TURN;
                    frame_cnt_r <= 8'd0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_battle_ctrl.sv
// Self-checking bench for battle_ctrl: directed scenarios pinned with literal values,
// then randomized play compared every cycle against a game-rule model.
module tb_battle_ctrl;

    logic       clk;
    logic       rst;
    logic       frame_tick;
    logic [6:0] switch;
    logic [9:0] sprite_x;
    logic [9:0] sprite_y;
    logic [7:0] player_hp;
    logic [7:0] enemy_hp;
    logic [2:0] state;
    logic       hit_flash;
    logic       busy;

    battle_ctrl dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .switch(switch),
        .sprite_x(sprite_x), .sprite_y(sprite_y), .player_hp(player_hp),
        .enemy_hp(enemy_hp), .state(state), .hit_flash(hit_flash), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    // Game model: state number, HPs, animation tick number, enemy tick number, flash frames.
    int m_st, m_php, m_ehp, m_x, m_at, m_et, m_flash;
    logic [6:0] h0, h1, h2;
    logic [6:0] sw_cur;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_php = 100; m_ehp = 100; m_x = 200;
        m_at = 0; m_et = 0; m_flash = 0;
        h0 = 7'd0; h1 = 7'd0; h2 = 7'd0;
    endtask

    task automatic model_step(input logic ft, input logic [6:0] sw);
        logic a, hl, r;
        bit load, clr;
        a = h1[0] & ~h2[0];
        hl = h1[1] & ~h2[1];
        r = h1[6] & ~h2[6];
        load = 0; clr = 0;
        case (m_st)
            0: begin
                if (a) begin
                    m_st = 1; m_at = 0;
                end else if (hl) begin
                    m_php = (m_php + 15 > 100) ? 100 : m_php + 15;
                    m_st = 3; m_et = 0;
                end
            end
            1: if (ft) begin
                m_at++;
                m_x = 200 + 4 * ((m_at <= 8) ? m_at : 16 - m_at);
                if (m_at == 16) m_st = 2;
            end
            2: begin
                m_ehp = (m_ehp < 20) ? 0 : m_ehp - 20;
                load = 1;
                m_st = (m_ehp == 0) ? 4 : 3;
                m_et = 0;
            end
            3: if (ft) begin
                m_et++;
                if (m_et == 32) begin
                    m_php = (m_php < 10) ? 0 : m_php - 10;
                    load = 1;
                    m_st = (m_php == 0) ? 5 : 0;
                end
            end
            default: if (r) begin
                m_php = 100; m_ehp = 100; m_x = 200;
                m_at = 0; m_et = 0; clr = 1; m_st = 0;
            end
        endcase
        if (clr) m_flash = 0;
        else if (load) m_flash = 8;
        else if (ft && m_flash > 0) m_flash--;
        h2 = h1; h1 = h0; h0 = sw;
    endtask

    task automatic compare_all();
        chk("state", int'(state), m_st);
        chk("player_hp", int'(player_hp), m_php);
        chk("enemy_hp", int'(enemy_hp), m_ehp);
        chk("sprite_x", int'(sprite_x), m_x);
        chk("sprite_y", int'(sprite_y), 400);
        chk("hit_flash", int'(hit_flash), (m_flash > 0) ? 1 : 0);
        chk("busy", int'(busy), (m_st == 0 || m_st == 4 || m_st == 5) ? 0 : 1);
    endtask

    // One clock: drive at negedge, advance model at posedge, compare at next negedge.
    task automatic step(input logic ft);
        frame_tick = ft;
        switch = sw_cur;
        @(posedge clk);
        if (rst) model_reset();
        else model_step(ft, sw_cur);
        @(negedge clk);
        compare_all();
    endtask

    task automatic press(input logic [6:0] mask);
        sw_cur = sw_cur | mask;
        repeat (4) step(1'b0);
        sw_cur = sw_cur & ~mask;
        repeat (4) step(1'b0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1);
            step(1'b0);
        end
    endtask

    initial begin
        rst = 1'b1; frame_tick = 1'b0; sw_cur = 7'd0; switch = 7'd0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_state", int'(state), 0);
        chk("rst_php", int'(player_hp), 100);
        chk("rst_ehp", int'(enemy_hp), 100);
        chk("rst_x", int'(sprite_x), 200);
        chk("rst_flash_busy", int'({hit_flash, busy}), 0);
        rst = 1'b0;
        step(1'b0);

        // Attack and full animation.
        press(7'b0000001);
        chk("atk_anim_state", int'(state), 1);
        ticks(8);
        chk("anim_peak_x", int'(sprite_x), 232);
        ticks(8);
        step(1'b0);
        chk("anim_end_x", int'(sprite_x), 200);
        chk("resolve_ehp", int'(enemy_hp), 80);
        chk("resolve_flash", int'(hit_flash), 1);
        chk("resolve_state", int'(state), 3);

        // Enemy turn, then saturating heal.
        ticks(32);
        chk("enemy_php", int'(player_hp), 90);
        chk("enemy_state", int'(state), 0);
        press(7'b0000010);
        chk("heal_php", int'(player_hp), 100);
        chk("heal_state", int'(state), 3);
        ticks(32);

        // Four more rounds to victory, then restart.
        for (int r = 2; r <= 5; r++) begin
            press(7'b0000001);
            ticks(16);
            step(1'b0);
            if (r < 5) ticks(32);
        end
        chk("victory_ehp", int'(enemy_hp), 0);
        chk("victory_state", int'(state), 4);
        press(7'b1000000);
        chk("restart_php", int'(player_hp), 100);
        chk("restart_ehp", int'(enemy_hp), 100);
        chk("restart_state", int'(state), 0);

        // Simultaneous attack/heal; attack during animation ignored.
        press(7'b0000011);
        chk("both_state", int'(state), 1);
        chk("both_php", int'(player_hp), 100);
        press(7'b0000001);
        ticks(16);
        step(1'b0);
        chk("single_hit_ehp", int'(enemy_hp), 80);
        ticks(32);

        // Reset in the middle of an animation.
        press(7'b0000001);
        ticks(5);
        rst = 1'b1;
        #1;
        chk("midrst_x", int'(sprite_x), 200);
        chk("midrst_ehp", int'(enemy_hp), 100);
        chk("midrst_state", int'(state), 0);
        model_reset();
        step(1'b0);
        step(1'b0);
        rst = 1'b0;
        step(1'b0);

        // Randomized play.
        for (int c = 0; c < 20000; c++) begin
            if ($urandom_range(0, 2999) == 0) begin
                rst = 1'b1;
                step(1'b0);
                step(1'b0);
                rst = 1'b0;
            end
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 3))
                    0: sw_cur[0] = ~sw_cur[0];
                    1: sw_cur[1] = ~sw_cur[1];
                    2: sw_cur[6] = ~sw_cur[6];
                    default: sw_cur[$urandom_range(2, 5)] = $urandom_range(0, 1) == 1;
                endcase
            end
            step($urandom_range(0, 2) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
